systolic_mm_param: RTL and testbench
====================================

Name: systolic_mm_param

Overview:
- Parametrised successor to the fixed 4x4 byte-serial systolic matrix multiplier.
- Computes C = A x B for N x N unsigned matrices over a valid/ready element stream.
- Buffers both operands and skews them into an N x N output-stationary PE grid, then drains C row-major under backpressure.
- Sits behind the SRAM driver / coprocessor FSM as the compute core.

Parameters:
- N, 4, matrix dimension (2..8).
- DW, 8, operand width (unsigned).
- AW, 20, accumulator width; must be >= 2*DW + clog2(N).
- OW, 8, result output width.

Ports:
- clk_p  in  1  clock, all logic on rising edge.
- rst_p  in  1  synchronous, active-high reset.
- start_p  in  1  one-cycle start request; honoured only in IDLE.
- in_valid_p  in  1  operand beat valid.
- in_ready_p  out  1  operand beat accepted when in_valid_p & in_ready_p.
- in_a_p  in  DW  element of A, row-major.
- in_b_p  in  DW  element of B, row-major.
- out_valid_p  out  1  result beat valid.
- out_ready_p  in  1  consumer ready.
- out_c_p  out  OW  element of C, row-major.
- busy_p  out  1  high in every state except IDLE.
- done_p  out  1  one-cycle pulse on the final output handshake.

Behaviour:
- Reset: synchronous, active-high. On rst_p=1 at a clock edge:
  - state <= IDLE.
  - All counters, buffers and accumulators <= 0.
  - in_ready_p, out_valid_p, busy_p, done_p = 0; out_c_p = 0.
  - Reset wins over every other input in the same cycle, including a reset that arrives mid-LOAD, mid-COMPUTE or mid-DRAIN.
- FSM states: IDLE -> LOAD -> COMPUTE -> DRAIN -> IDLE.
- IDLE:
  - start_p=1 moves to LOAD next cycle and clears all accumulators.
  - start_p in any other state is ignored.
- LOAD:
  - in_ready_p=1.
  - Beat k (0..N*N-1) writes A[k/N][k%N] and B[k/N][k%N] into the operand buffers.
  - Cycles with in_valid_p=0 do not advance k.
  - The handshake at k=N*N-1 moves to COMPUTE; in_ready_p drops in the following cycle.
- COMPUTE:
  - Lasts exactly 3N-1 cycles (11 for N=4), driven by a cycle counter t.
  - Row i of A enters the left edge delayed by i cycles; column j of B enters the top edge delayed by j cycles.
  - Zeros are injected outside the valid window.
  - Each PE(i,j) does acc <= acc + a*b, with the product at 2*DW bits and the accumulator at AW bits (wraps modulo 2^AW), then passes a right and b down with 1-cycle registers.
  - On the last cycle, moves to DRAIN.
- DRAIN:
  - out_valid_p=1 starting the first cycle after COMPUTE.
  - out_c_p = C[m/N][m%N] for m = 0..N*N-1.
  - m advances only on out_valid_p & out_ready_p.
  - out_c_p is held stable while stalled.
  - The handshake at m=N*N-1 asserts done_p for that cycle; IDLE follows the next cycle with out_valid_p=0.
- Output width: by default out_c_p = acc[OW-1:0] (truncation).
- Total latency with no stalls: N*N load + (3N-1) compute + N*N drain cycles after the start_p cycle + 1.

Optional Feature:
- Macro: SYS_MM_OUT_SAT_EN.
- When defined: out_c_p = (acc > 2^OW-1) ? 2^OW-1 : acc[OW-1:0] (unsigned saturation), and acc=2^OW-1 passes through unchanged.
- When undefined: plain truncation to OW bits, and no comparator logic is synthesised.

Test Plan:
- N=4, OW=8: A rows all {1,2,3,4}, B row r all r+1 -> 16 output beats, each equal to 30; done_p on beat 16; busy_p falls the next cycle.
- A = {1111; 1001; 1001; 1111}, B[r][c] = 12+2*(4r+c) -> C rows {96,104,112,120}, {48,52,56,60}, {48,52,56,60}, {96,104,112,120}.
- A[r][c] = 3*(4r+c), B = {2001; 0210; 0120; 1002} -> C rows {9,12,15,18}, {45,48,51,54}, {81,84,87,90}, {117,120,123,126}. Run it with in_valid_p toggled 1/0 every cycle and out_ready_p low for 3 cycles at m=5: results must be identical and out_c_p must hold 48 while stalled.
- OW=16, all operands 255 (true element 260100): SYS_MM_OUT_SAT_EN defined -> every beat is 65535; undefined -> every beat is 63492.
- Assert rst_p for one cycle at load beat 7 and again mid-DRAIN: in_ready_p, out_valid_p and busy_p are 0 the next cycle. A fresh start_p with the first test's data must then yield all 30s, with no stale accumulation.
- start_p pulsed during LOAD and during DRAIN is ignored, with the beat count unchanged. start_p issued with rst_p=1 stays in IDLE.

Source files
------------

// File: rtl/systolic_mm_param.sv
// ============================================================================
// Module   : systolic_mm_param
// Purpose  : N x N output-stationary systolic matrix multiplier C = A x B,
//            fed by a row-major operand stream and drained row-major under
//            backpressure. Optional macro SYS_MM_OUT_SAT_EN selects unsigned
//            saturation of results to OW bits instead of truncation.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module systolic_mm_param #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = 20,
  parameter int OW = 8
) (
  input  logic          clk_p,
  input  logic          rst_p,
  input  logic          start_p,
  input  logic          in_valid_p,
  output logic          in_ready_p,
  input  logic [DW-1:0] in_a_p,
  input  logic [DW-1:0] in_b_p,
  output logic          out_valid_p,
  input  logic          out_ready_p,
  output logic [OW-1:0] out_c_p,
  output logic          busy_p,
  output logic          done_p
);

  localparam int C_NN    = N * N;
  localparam int C_KW    = $clog2(C_NN);
  localparam int C_TW    = $clog2(3 * N - 1);
  localparam int C_TLAST = 3 * N - 2;
`ifdef SYS_MM_OUT_SAT_EN
  localparam int C_SW = AW;
`else
  localparam int C_SW = OW;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [C_KW-1:0]   k_q, k_d;
  logic [C_KW-1:0]   m_q, m_d;
  logic [C_TW-1:0]   t_q, t_d;

  logic [DW-1:0]     a_buf_q [C_NN];
  logic [DW-1:0]     b_buf_q [C_NN];

  logic [DW-1:0]     w_edge_a [N];
  logic [DW-1:0]     w_edge_b [N];
  logic [DW-1:0]     w_a_pass [N][N-1];
  logic [DW-1:0]     w_b_pass [N-1][N];
  logic [C_SW-1:0]   w_acc    [C_NN];
  logic [C_SW-1:0]   w_sel;
  logic [OW-1:0]     w_res;
  logic              w_clear;

  assign w_clear = (state_q == S_IDLE) && start_p;

  // ---------------------------------------------------------------- control
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    t_d     = t_q;
    m_d     = m_q;
    case (state_q)
      S_IDLE: begin
        if (start_p) begin
          state_d = S_LOAD;
          k_d     = '0;
        end
      end
      S_LOAD: begin
        if (in_valid_p) begin
          k_d = k_q + 1'b1;
          if (k_q == C_KW'(C_NN - 1)) begin
            state_d = S_COMPUTE;
            t_d     = '0;
          end
        end
      end
      S_COMPUTE: begin
        t_d = t_q + 1'b1;
        if (t_q == C_TW'(C_TLAST)) begin
          state_d = S_DRAIN;
          m_d     = '0;
        end
      end
      S_DRAIN: begin
        if (out_ready_p) begin
          m_d = m_q + 1'b1;
          if (m_q == C_KW'(C_NN - 1)) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      t_q     <= '0;
      m_q     <= '0;
      for (int i = 0; i < C_NN; i++) begin
        a_buf_q[i] <= '0;
        b_buf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      t_q     <= t_d;
      m_q     <= m_d;
      if ((state_q == S_LOAD) && in_valid_p) begin
        a_buf_q[k_q] <= in_a_p;
        b_buf_q[k_q] <= in_b_p;
      end
    end
  end

  // Row i of A and column j of B enter skewed by i (resp. j) cycles.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_edge_a[i] = '0;
      w_edge_b[i] = '0;
      if ((state_q == S_COMPUTE) && (int'(t_q) >= i) && (int'(t_q) < i + N)) begin
        w_edge_a[i] = a_buf_q[C_KW'(i * N + int'(t_q) - i)];
        w_edge_b[i] = b_buf_q[C_KW'((int'(t_q) - i) * N + i)];
      end
    end
  end

  // ---------------------------------------------------------------- PE grid
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [DW-1:0]   w_a_in;
      logic [DW-1:0]   w_b_in;
      logic [2*DW-1:0] w_prod;
      logic [AW-1:0]   acc_q;

      if (gj == 0) begin : g_a_edge
        assign w_a_in = w_edge_a[gi];
      end else begin : g_a_link
        assign w_a_in = w_a_pass[gi][gj-1];
      end

      if (gi == 0) begin : g_b_edge
        assign w_b_in = w_edge_b[gj];
      end else begin : g_b_link
        assign w_b_in = w_b_pass[gi-1][gj];
      end

      assign w_prod = {{DW{1'b0}}, w_a_in} * {{DW{1'b0}}, w_b_in};

      always_ff @(posedge clk_p) begin
        if (rst_p || w_clear) begin
          acc_q <= '0;
        end else if (state_q == S_COMPUTE) begin
          acc_q <= acc_q + {{(AW - 2*DW){1'b0}}, w_prod};
        end
      end

      // Edge PEs have no right/lower neighbour, so they carry no pass register.
      if (gj < N - 1) begin : g_a_reg
        logic [DW-1:0] a_q;
        always_ff @(posedge clk_p) begin
          if (rst_p || w_clear) begin
            a_q <= '0;
          end else if (state_q == S_COMPUTE) begin
            a_q <= w_a_in;
          end
        end
        assign w_a_pass[gi][gj] = a_q;
      end

      if (gi < N - 1) begin : g_b_reg
        logic [DW-1:0] b_q;
        always_ff @(posedge clk_p) begin
          if (rst_p || w_clear) begin
            b_q <= '0;
          end else if (state_q == S_COMPUTE) begin
            b_q <= w_b_in;
          end
        end
        assign w_b_pass[gi][gj] = b_q;
      end

      assign w_acc[gi*N + gj] = acc_q[C_SW-1:0];
    end
  end

  // ---------------------------------------------------------------- output
  assign w_sel = w_acc[m_q];

`ifdef SYS_MM_OUT_SAT_EN
  assign w_res = (|w_sel[AW-1:OW]) ? {OW{1'b1}} : w_sel[OW-1:0];
`else
  assign w_res = w_sel;
`endif

  assign in_ready_p  = (state_q == S_LOAD);
  assign out_valid_p = (state_q == S_DRAIN);
  assign busy_p      = (state_q != S_IDLE);
  assign done_p      = (state_q == S_DRAIN) && out_ready_p && (m_q == C_KW'(C_NN - 1));
  assign out_c_p     = (state_q == S_DRAIN) ? w_res : '0;

endmodule

`default_nettype wire

// File: tb/tb_systolic_mm_param.sv
// ============================================================================
// Module   : tb_systolic_mm_param
// Purpose  : Directed self-checking bench for systolic_mm_param (N=4, OW=16)
//            against a plain matrix-multiply reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_systolic_mm_param;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 20;
  localparam int OW = 16;
  localparam int NN = N * N;

  typedef int mat_t [NN];

  logic          clk_p = 1'b0;
  logic          rst_p;
  logic          start_p;
  logic          in_valid_p;
  logic          in_ready_p;
  logic [DW-1:0] in_a_p;
  logic [DW-1:0] in_b_p;
  logic          out_valid_p;
  logic          out_ready_p;
  logic [OW-1:0] out_c_p;
  logic          busy_p;
  logic          done_p;

  int total = 0;
  int bad   = 0;
  int exp_q [$];

  systolic_mm_param #(.N(N), .DW(DW), .AW(AW), .OW(OW)) dut (
    .clk_p      (clk_p),
    .rst_p      (rst_p),
    .start_p    (start_p),
    .in_valid_p (in_valid_p),
    .in_ready_p (in_ready_p),
    .in_a_p     (in_a_p),
    .in_b_p     (in_b_p),
    .out_valid_p(out_valid_p),
    .out_ready_p(out_ready_p),
    .out_c_p    (out_c_p),
    .busy_p     (busy_p),
    .done_p     (done_p)
  );

  always #5 clk_p = ~clk_p;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  // Reference: exact product sum, wrapped to AW bits, then reduced to OW bits.
  function automatic int model_out(input longint s);
    longint acc;
    longint omax;
    acc  = s & ((longint'(1) << AW) - 1);
    omax = (longint'(1) << OW) - 1;
`ifdef SYS_MM_OUT_SAT_EN
    return int'((acc > omax) ? omax : acc);
`else
    return int'(acc & omax);
`endif
  endfunction

  task automatic model_mm(input mat_t a, input mat_t b, output mat_t c);
    longint s;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int p = 0; p < N; p++) s += longint'(a[i*N+p]) * longint'(b[p*N+j]);
        c[i*N+j] = model_out(s);
      end
    end
  endtask

  // Scoreboard: every presented result must match the model; done_p only on the last handshake.
  always @(negedge clk_p) begin
    if (!rst_p) begin
      if (out_valid_p) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 64'd1, 64'd0);
        end else begin
          check("out_c", out_c_p, exp_q[0]);
          if (out_ready_p) begin
            check("done_on_last", done_p, exp_q.size() == 1);
            void'(exp_q.pop_front());
          end
        end
      end else if (done_p) begin
        check("done_without_valid", done_p, 64'd0);
      end
    end
  end

  task automatic mid_reset();
    rst_p       = 1'b1;
    in_valid_p  = 1'b1;
    out_ready_p = 1'b0;
    start_p     = 1'b0;
    @(posedge clk_p); #1;
    rst_p       = 1'b0;
    in_valid_p  = 1'b0;
    out_ready_p = 1'b1;
    exp_q.delete();
    check("rst_in_ready", in_ready_p, 64'd0);
    check("rst_out_valid", out_valid_p, 64'd0);
    check("rst_busy", busy_p, 64'd0);
    check("rst_out_c", out_c_p, 64'd0);
  endtask

  // rst_mode: 0 none, 1 reset at load beat 7, 2 reset mid-drain (m=8)
  task automatic run_job(input mat_t a, input mat_t b, input bit toggle, input bit stall,
                         input int hold_exp, input int rst_mode, input bit start_noise);
    mat_t c;
    int   k, m, cyc, stall_cnt, guard;
    bit   hs, dn, ph;
    model_mm(a, b, c);
    for (int i = 0; i < NN; i++) exp_q.push_back(c[i]);
    start_p = 1'b1;
    @(posedge clk_p); #1;
    start_p = 1'b0;
    cyc = 0; k = 0; guard = 0; ph = 1'b1;
    while (k < NN && guard < 100) begin
      if (rst_mode == 1 && k == 7) begin
        mid_reset();
        return;
      end
      in_valid_p = toggle ? ph : 1'b1;
      ph         = !ph;
      in_a_p     = DW'(a[k]);
      in_b_p     = DW'(b[k]);
      start_p    = start_noise && (k == 3);
      #1;
      hs = in_valid_p && in_ready_p;
      @(posedge clk_p); #1;
      cyc++; guard++;
      if (hs) k++;
    end
    start_p    = 1'b0;
    in_valid_p = 1'b0;
    check("load_beats", k, NN);
    check("in_ready_drop", in_ready_p, 64'd0);
    m = 0; stall_cnt = 0; guard = 0; dn = 1'b0;
    while (!dn && guard < 300) begin
      if (rst_mode == 2 && m == 8) begin
        mid_reset();
        return;
      end
      if (stall && m == 5 && stall_cnt < 3) begin
        out_ready_p = 1'b0;
        stall_cnt++;
      end else begin
        out_ready_p = 1'b1;
      end
      start_p = start_noise && (m == 2);
      #1;
      if (!out_ready_p) check("stall_hold", out_c_p, hold_exp);
      hs = out_valid_p && out_ready_p;
      dn = hs && done_p;
      @(posedge clk_p); #1;
      cyc++; guard++;
      if (hs) m++;
    end
    start_p     = 1'b0;
    out_ready_p = 1'b1;
    check("done_seen", dn, 64'd1);
    check("drain_beats", m, NN);
    check("busy_fall", busy_p, 64'd0);
    check("valid_fall", out_valid_p, 64'd0);
    check("model_drained", exp_q.size(), 64'd0);
    if (!toggle && !stall) check("latency", cyc, 2*NN + 3*N - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mat_t a1, b1, a2, b2, a3, b3, a4, c;
    for (int k = 0; k < NN; k++) begin
      a1[k] = (k % N) + 1;
      b1[k] = (k / N) + 1;
      a2[k] = ((k / N) == 0 || (k / N) == 3 || (k % N) == 0 || (k % N) == 3) ? 1 : 0;
      b2[k] = 12 + 2 * k;
      a3[k] = 3 * k;
      a4[k] = 255;
    end
    b3 = '{2,0,0,1, 0,2,1,0, 0,1,2,0, 1,0,0,2};

    rst_p = 1'b1; start_p = 1'b0; in_valid_p = 1'b0; out_ready_p = 1'b1;
    in_a_p = '0; in_b_p = '0;
    repeat (2) @(posedge clk_p);
    #1 rst_p = 1'b0;
    check("reset_in_ready", in_ready_p, 64'd0);
    check("reset_out_valid", out_valid_p, 64'd0);
    check("reset_busy", busy_p, 64'd0);
    check("reset_done", done_p, 64'd0);
    check("reset_out_c", out_c_p, 64'd0);

    model_mm(a1, b1, c);
    check("pin_t1_c00", c[0], 64'd30);
    check("pin_t1_c15", c[15], 64'd30);
    model_mm(a2, b2, c);
    check("pin_t2_c12", c[6], 64'd56);
    check("pin_t2_c33", c[15], 64'd120);
    model_mm(a3, b3, c);
    check("pin_t3_c00", c[0], 64'd9);
    check("pin_t3_c11", c[5], 64'd48);
    check("pin_t3_c33", c[15], 64'd126);
    model_mm(a4, a4, c);
`ifdef SYS_MM_OUT_SAT_EN
    check("pin_t4_sat", c[0], 64'd65535);
`else
    check("pin_t4_trunc", c[0], 64'd63492);
`endif

    run_job(a1, b1, 1'b0, 1'b0, 0, 0, 1'b0);
    run_job(a2, b2, 1'b0, 1'b0, 0, 0, 1'b0);
    run_job(a3, b3, 1'b1, 1'b1, 48, 0, 1'b0);
    run_job(a4, a4, 1'b0, 1'b0, 0, 0, 1'b0);

    run_job(a2, b2, 1'b0, 1'b0, 0, 1, 1'b0);
    run_job(a3, b3, 1'b0, 1'b0, 0, 2, 1'b0);
    run_job(a1, b1, 1'b0, 1'b0, 0, 0, 1'b0);

    run_job(a2, b2, 1'b0, 1'b0, 0, 0, 1'b1);

    rst_p = 1'b1; start_p = 1'b1;
    @(posedge clk_p); #1;
    rst_p = 1'b0; start_p = 1'b0;
    check("start_in_reset_busy", busy_p, 64'd0);
    check("start_in_reset_ready", in_ready_p, 64'd0);
    @(posedge clk_p); #1;
    check("start_in_reset_busy_next", busy_p, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
